// File: rtl/axis_flit_if.sv
// AXI-Stream beat interface feeding the flit packetizer.
// A beat transfers on a rising clock edge where tvalid && tready; the source holds
// tvalid and all payload fields stable until that edge, and tready never depends on tvalid.
interface axis_flit_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TDEST_WIDTH = 4,
  parameter int TID_WIDTH   = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (
    output tvalid, tdata, tlast, tid, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tid, tdest,
    output tready
  );
endinterface

// File: rtl/axis_flit_packetizer.sv
// Splits each AXIS beat into SERIALIZATION_FACTOR flits (LSB slice first) and issues
// them to a router port under credit-based flow control.
module axis_flit_packetizer #(
  parameter int TDATA_WIDTH          = 256,
  parameter int TDEST_WIDTH          = 4,
  parameter int TID_WIDTH            = 2,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 2,
  localparam int FLIT_WIDTH   = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int DEST_WIDTH   = TDEST_WIDTH + TID_WIDTH,
  localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_n,
  axis_flit_if.slave              axis_in,
  output logic [FLIT_WIDTH-1:0]   data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_err
);

  localparam int IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IDX_WIDTH-1:0]    IDX_LAST   = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  logic                   hold_valid;
  logic                   hold_last;
  logic [TDATA_WIDTH-1:0] hold_data;
  logic [DEST_WIDTH-1:0]  hold_dest;
  logic [IDX_WIDTH-1:0]   idx;

  logic                  fire;
  logic                  last_flit;
  logic                  accept;
  logic [FLIT_WIDTH-1:0] flit_sel;

  assign fire      = hold_valid && (credit_count != '0);
  assign last_flit = (idx == IDX_LAST);
  // Refill on the same edge as the final flit so consecutive beats leave no bubble.
  assign axis_in.tready = !hold_valid || (fire && last_flit);
  assign accept    = axis_in.tvalid && axis_in.tready;
  assign flit_sel  = hold_data[idx*FLIT_WIDTH +: FLIT_WIDTH];

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      hold_data  <= '0;
      hold_dest  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_last  <= axis_in.tlast;
      hold_data  <= axis_in.tdata;
      hold_dest  <= {axis_in.tid, axis_in.tdest};
    end else if (fire && last_flit) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (fire) begin
      idx <= last_flit ? '0 : idx + IDX_WIDTH'(1);
    end
  end

  // Flit fields hold their last value between sends; only send_out pulses.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= fire;
      if (fire) begin
        data_out    <= flit_sel;
        dest_out    <= hold_dest;
        is_tail_out <= hold_last && last_flit;
      end
    end
  end

  // A returned credit at full count has no slot to refill: saturate and flag it.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_count <= CREDIT_MAX;
      credit_err   <= 1'b0;
    end else begin
      case ({fire, credit_in})
        2'b10: credit_count <= credit_count - CREDIT_WIDTH'(1);
        2'b01: begin
          if (credit_count == CREDIT_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credit_count <= credit_count + CREDIT_WIDTH'(1);
          end
        end
        default: credit_count <= credit_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_flit_packetizer.sv
// Bench for axis_flit_packetizer: an SF=4 instance checked every cycle against a flit-queue
// model, plus an SF=1 instance for single-flit beats.
module tb_axis_flit_packetizer;
  localparam int TDW   = 32;
  localparam int SF    = 4;
  localparam int DEPTH = 2;
  localparam int FW    = TDW / SF;
  localparam int DW    = 6;
  localparam int CW    = 2;
  localparam int EW    = 1 + DW + FW;

  // ---------------- clock / reset ----------------
  logic clk_noc = 1'b0;
  logic rst_n;
  always #5 clk_noc = ~clk_noc;

  int cyc = 0;
  always @(posedge clk_noc) cyc = cyc + 1;

  axis_flit_if #(.TDATA_WIDTH(TDW), .TDEST_WIDTH(4), .TID_WIDTH(2)) a4 ();
  axis_flit_if #(.TDATA_WIDTH(TDW), .TDEST_WIDTH(4), .TID_WIDTH(2)) a1 ();

  logic [FW-1:0]  data4;
  logic [DW-1:0]  dest4;
  logic           tail4, send4, credit4, err4;
  logic [CW-1:0]  cnt4;
  logic [TDW-1:0] data1;
  logic [DW-1:0]  dest1;
  logic           tail1, send1, credit1, err1;
  logic [CW-1:0]  cnt1;

  axis_flit_packetizer #(
    .TDATA_WIDTH(TDW), .TDEST_WIDTH(4), .TID_WIDTH(2),
    .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut4 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis_in(a4),
    .data_out(data4), .dest_out(dest4), .is_tail_out(tail4), .send_out(send4),
    .credit_in(credit4), .credit_count(cnt4), .credit_err(err4)
  );

  axis_flit_packetizer #(
    .TDATA_WIDTH(TDW), .TDEST_WIDTH(4), .TID_WIDTH(2),
    .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut1 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis_in(a1),
    .data_out(data1), .dest_out(dest1), .is_tail_out(tail1), .send_out(send1),
    .credit_in(credit1), .credit_count(cnt1), .credit_err(err1)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- scoreboard / behavioural model (SF=4 instance) ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            obs_cyc[$];
  int            m_avail = DEPTH;
  bit            m_err, m_send, m_tready, m_fire;
  logic [EW-1:0] m_last = '0;
  int            pend;

  always @(negedge clk_noc) begin
    if (!rst_n) begin
      exp_q.delete();
      m_avail = DEPTH;
      m_err   = 1'b0;
      m_send  = 1'b0;
      m_last  = '0;
      chk("rst_send", send4, 0);
      chk("rst_flit", {tail4, dest4, data4}, 0);
      chk("rst_credits", cnt4, DEPTH);
      chk("rst_err", err4, 0);
      chk("rst_tready", a4.tready, 1);
    end else begin
      chk("send", send4, m_send);
      chk("flit", {tail4, dest4, data4}, m_last);
      chk("credits", cnt4, m_avail);
      chk("credit_err", err4, m_err);
      pend     = exp_q.size();
      // Ready when nothing is left, or only the final flit remains and it can go now.
      m_tready = (pend == 0) || (pend == 1 && m_avail > 0);
      chk("tready", a4.tready, m_tready);
      if (send4) begin
        obs_q.push_back({tail4, dest4, data4});
        obs_cyc.push_back(cyc);
      end
      m_fire = (pend > 0) && (m_avail > 0);
      if (m_fire) m_last = exp_q.pop_front();
      m_send  = m_fire;
      m_avail = m_avail - int'(m_fire) + int'(credit4);
      if (m_avail > DEPTH) begin
        m_avail = DEPTH;
        m_err   = 1'b1;
      end
      if (a4.tvalid && m_tready) begin
        for (int k = 0; k < SF; k++)
          exp_q.push_back({(k == SF - 1) && a4.tlast, a4.tid, a4.tdest, a4.tdata[k*FW +: FW]});
      end
    end
  end

  // SF=1 observer
  bit             t6_on = 1'b0;
  logic [38:0]    obs1[$];
  always @(negedge clk_noc) begin
    if (rst_n && t6_on) begin
      if (send1) obs1.push_back({tail1, dest1, data1});
      if (cnt1 != 0) chk("t6_tready", a1.tready, 1);
    end
  end

  // ---------------- driver tasks ----------------
  int mode = 0;      // 0: manual credits, 1: echo send_out, 2: random return
  int out_cnt = 0;
  bit acc4, acc1;

  task automatic tick();
    @(negedge clk_noc);
    acc4 = a4.tvalid && a4.tready;
    acc1 = a1.tvalid && a1.tready;
    @(posedge clk_noc);
    #1;
    case (mode)
      1: credit4 = send4;
      2: begin
        if (send4) out_cnt++;
        if (out_cnt > 0 && $urandom_range(0, 2) != 0) begin
          credit4 = 1'b1;
          out_cnt--;
        end else begin
          credit4 = 1'b0;
        end
      end
      default: credit4 = 1'b0;
    endcase
    credit1 = send1;
  endtask

  task automatic wait_acc4();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc4) break;
    end
    chk("beat_accept", acc4, 1);
  endtask

  task automatic send_beat4(input logic [31:0] d, input logic l, input logic [1:0] id,
                            input logic [3:0] de);
    a4.tdata  = d;
    a4.tlast  = l;
    a4.tid    = id;
    a4.tdest  = de;
    a4.tvalid = 1'b1;
    wait_acc4();
    a4.tvalid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int          pulse_cyc, b_cyc, nsent;
  logic [31:0] w [3];

  initial begin
    rst_n = 1'b0;
    credit4 = 1'b0; credit1 = 1'b0;
    a4.tvalid = 1'b0; a4.tdata = '0; a4.tlast = 1'b0; a4.tid = '0; a4.tdest = '0;
    a1.tvalid = 1'b0; a1.tdata = '0; a1.tlast = 1'b0; a1.tid = '0; a1.tdest = '0;
    repeat (3) @(posedge clk_noc);
    #1 rst_n = 1'b1;

    // Single beat, ample credits
    mode = 1; obs_q.delete(); obs_cyc.delete();
    send_beat4(32'hDDCCBBAA, 1'b1, 2'd2, 4'd5);
    repeat (8) tick();
    chk("t1_count", obs_q.size(), 4);
    chk("t1_flit0", obs_q[0], {1'b0, 6'h25, 8'hAA});
    chk("t1_flit1", obs_q[1], {1'b0, 6'h25, 8'hBB});
    chk("t1_flit2", obs_q[2], {1'b0, 6'h25, 8'hCC});
    chk("t1_flit3", obs_q[3], {1'b1, 6'h25, 8'hDD});
    chk("t1_consecutive", obs_cyc[3] - obs_cyc[0], 3);

    // Credit starvation and single-credit release
    mode = 0; obs_q.delete(); obs_cyc.delete();
    send_beat4(32'h44332211, 1'b0, 2'd1, 4'd3);
    repeat (5) tick();
    chk("t2_two_flits", obs_q.size(), 2);
    chk("t2_send_idle", send4, 0);
    chk("t2_credits_zero", cnt4, 0);
    pulse_cyc = cyc;
    credit4 = 1'b1;
    repeat (3) tick();
    chk("t2_one_more", obs_q.size(), 3);
    chk("t2_issue_edge", obs_cyc[2], pulse_cyc + 2);
    chk("t2_flit2", obs_q[2], {1'b0, 6'h13, 8'h33});
    credit4 = 1'b1;
    repeat (3) tick();
    chk("t2_flit3", obs_q[3], {1'b0, 6'h13, 8'h44});
    credit4 = 1'b1; tick();
    credit4 = 1'b1; tick();
    tick();
    chk("t2_credits_full", cnt4, DEPTH);

    // Back-to-back beats with tvalid held high
    mode = 1; obs_q.delete(); obs_cyc.delete();
    a4.tdata = 32'h13121110; a4.tlast = 1'b0; a4.tid = 2'd1; a4.tdest = 4'd2; a4.tvalid = 1'b1;
    wait_acc4();
    a4.tdata = 32'h17161514; a4.tlast = 1'b1;
    wait_acc4();
    b_cyc = cyc;
    a4.tvalid = 1'b0;
    repeat (10) tick();
    chk("t3_count", obs_q.size(), 8);
    for (int i = 1; i < 8; i++) chk("t3_consecutive", obs_cyc[i] - obs_cyc[i-1], 1);
    chk("t3_tready_on_4th", b_cyc, obs_cyc[3]);
    chk("t3_flit3", obs_q[3], {1'b0, 6'h12, 8'h13});
    chk("t3_flit7", obs_q[7], {1'b1, 6'h12, 8'h17});

    // Randomized traffic with randomly returned credits
    mode = 2; out_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!a4.tvalid || acc4) begin
        if ($urandom_range(0, 3) != 0) begin
          a4.tvalid = 1'b1;
          a4.tdata  = $urandom();
          a4.tlast  = 1'($urandom_range(0, 1));
          a4.tid    = 2'($urandom_range(0, 3));
          a4.tdest  = 4'($urandom_range(0, 15));
        end else begin
          a4.tvalid = 1'b0;
        end
      end
    end
    for (int i = 0; i < 50; i++) begin
      if (!a4.tvalid || acc4) break;
      tick();
    end
    a4.tvalid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && out_cnt == 0 && !send4) break;
      tick();
    end
    chk("drain_model_empty", exp_q.size(), 0);
    tick(); tick();
    chk("drain_credits", cnt4, DEPTH);

    // Credit overflow and simultaneous fire + credit
    mode = 0;
    credit4 = 1'b1; tick(); tick();
    chk("t4_saturate", cnt4, DEPTH);
    chk("t4_err_set", err4, 1);
    send_beat4(32'hA5A55A5A, 1'b1, 2'd0, 4'd0);
    tick();
    credit4 = 1'b1;
    tick();
    chk("t4_fire_and_credit", cnt4, 1);
    mode = 1;
    repeat (10) tick();
    chk("t4_err_sticky", err4, 1);

    // Reset mid-beat
    mode = 1; nsent = 0;
    send_beat4(32'h88776655, 1'b1, 2'd3, 4'd9);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (send4) nsent++;
      if (nsent == 2) break;
    end
    rst_n = 1'b0; mode = 0; credit4 = 1'b0;
    #1;
    chk("t5_send_zero", send4, 0);
    chk("t5_flit_zero", {tail4, dest4, data4}, 0);
    chk("t5_credits", cnt4, DEPTH);
    chk("t5_tready", a4.tready, 1);
    chk("t5_err_cleared", err4, 0);
    tick(); tick();
    rst_n = 1'b1;
    obs_q.delete(); obs_cyc.delete();
    repeat (6) tick();
    chk("t5_no_residual", obs_q.size(), 0);
    mode = 1;
    send_beat4(32'h04030201, 1'b1, 2'd0, 4'd1);
    repeat (8) tick();
    chk("t5_count", obs_q.size(), 4);
    chk("t5_first_flit", obs_q[0], {1'b0, 6'h01, 8'h01});
    chk("t5_last_flit", obs_q[3], {1'b1, 6'h01, 8'h04});

    // SF=1: three-beat packet
    t6_on = 1'b1;
    for (int b = 0; b < 3; b++) w[b] = $urandom();
    a1.tid = 2'd1; a1.tdest = 4'd3; a1.tvalid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      a1.tdata = w[b];
      a1.tlast = (b == 2);
      for (int i = 0; i < 50; i++) begin
        tick();
        if (acc1) break;
      end
      chk("t6_accept", acc1, 1);
    end
    a1.tvalid = 1'b0;
    repeat (5) tick();
    chk("t6_count", obs1.size(), 3);
    for (int b = 0; b < 3; b++) chk("t6_flit", obs1[b], {b == 2, 6'h13, w[b]});
    t6_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
